// File: rtl/prbs_seq_ctrl_pkg.sv
// Shared types and constants for the PRBS sequence controller and its byte checker.
package prbs_pkg;

    localparam int BYTE_W = 8;
    localparam int PAT_W  = 32;
    localparam logic [BYTE_W-1:0] SAT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

    function automatic logic [BYTE_W-1:0] sat_inc(input logic [BYTE_W-1:0] v, input logic inc);
        return (inc && (v != SAT_MAX)) ? v + 1'b1 : v;
    endfunction

endpackage

// File: rtl/prbs_seq_ctrl_if.sv
// Controller <-> PRBS/pattern-detector datapath bus.
interface prbs_seq_ctrl_if;
    import prbs_pkg::*;

    logic              dp_rstn;
    logic [PAT_W-1:0]  dp_in;
    logic [BYTE_W-1:0] dp_n;
    logic [BYTE_W-1:0] dp_out;
    logic              dp_detected;

    // No handshake: dp_out is a byte every cycle while dp_rstn is high; dp_detected is a one-cycle strobe.
    modport master (output dp_rstn, dp_in, dp_n, input dp_out, dp_detected);
    modport slave  (input dp_rstn, dp_in, dp_n, output dp_out, dp_detected);

endinterface

// File: rtl/prbs_seq_ctrl_byte_checker.sv
// Walks the seed pattern MSB-byte first and flags bytes that differ from the datapath stream.
module prbs_byte_checker
    import prbs_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              en,
    input  logic [PAT_W-1:0]  pattern,
    input  logic [BYTE_W-1:0] data,
    output logic              mismatch,
    output logic              wrap
);

    logic [1:0]        idx;
    logic [BYTE_W-1:0] exp_byte;

    // idx counts 3..0 and wraps naturally through the 2-bit width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= 2'd3;
        end else if (clear) begin
            idx <= 2'd3;
        end else if (en) begin
            idx <= idx - 2'd1;
        end
    end

    assign exp_byte = pattern[{idx, 3'b111} -: BYTE_W];
    assign mismatch = en && (data != exp_byte);
    assign wrap     = en && (idx == 2'd0);

endmodule

// File: rtl/prbs_seq_ctrl.sv
// Test-run sequencer: loads the datapath, checks its byte stream and detections, reports pass/fail.
module prbs_seq_ctrl
    import prbs_pkg::*;
#(
    parameter int TO_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic [BYTE_W-1:0] cfg_n,
    input  logic [TO_W-1:0]   cfg_timeout,
    prbs_seq_ctrl_if.master   dp,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [BYTE_W-1:0] det_count,
    output logic [BYTE_W-1:0] err_count,
    output state_t            state_dbg
);

    state_t            state;
    logic [PAT_W-1:0]  shadow_pattern;
    logic [BYTE_W-1:0] shadow_n;
    logic [TO_W-1:0]   shadow_timeout;
    logic [BYTE_W-1:0] grp_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              timed_out;
    logic              dp_rstn_q;
    logic              mismatch;
    logic              wrap;
    logic [TO_W-1:0]   to_next;
    logic [BYTE_W-1:0] grp_next;
    logic [BYTE_W-1:0] det_next;

    prbs_byte_checker u_checker (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state != ST_RUN),
        .en       (state == ST_RUN),
        .pattern  (shadow_pattern),
        .data     (dp.dp_out),
        .mismatch (mismatch),
        .wrap     (wrap)
    );

    assign dp.dp_rstn = dp_rstn_q;
    assign dp.dp_in   = shadow_pattern;
    assign dp.dp_n    = shadow_n;
    assign state_dbg  = state;
    assign to_next    = to_cnt + 1'b1;
    assign grp_next   = grp_cnt + 1'b1;
    assign det_next   = sat_inc(det_count, dp.dp_detected);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            shadow_pattern <= '0;
            shadow_n       <= '0;
            shadow_timeout <= '0;
            grp_cnt        <= '0;
            to_cnt         <= '0;
            timed_out      <= 1'b0;
            dp_rstn_q      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            det_count      <= '0;
            err_count      <= '0;
        end else begin
            done <= 1'b0;
            if (abort && (state != ST_IDLE)) begin
                state     <= ST_IDLE;
                dp_rstn_q <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
                pass      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            pass      <= 1'b0;
                            det_count <= '0;
                            err_count <= '0;
                            if (cfg_n == '0) begin
                                done <= 1'b1;
                            end else begin
                                shadow_pattern <= cfg_pattern;
                                shadow_n       <= cfg_n;
                                shadow_timeout <= cfg_timeout;
                                grp_cnt        <= '0;
                                to_cnt         <= '0;
                                timed_out      <= 1'b0;
                                busy           <= 1'b1;
                                state          <= ST_LOAD;
                            end
                        end
                    end
                    ST_LOAD: begin
                        dp_rstn_q <= 1'b1;
                        state     <= ST_RUN;
                    end
                    ST_RUN: begin
                        err_count <= sat_inc(err_count, mismatch);
                        det_count <= det_next;
                        to_cnt    <= to_next;
                        if (wrap) grp_cnt <= grp_next;
                        // Timeout is tested first so it wins over a same-cycle final group.
                        if (to_next == shadow_timeout) begin
                            timed_out <= 1'b1;
                            dp_rstn_q <= 1'b0;
                            state     <= ST_CHECK;
                        end else if (wrap && (grp_next == shadow_n)) begin
                            dp_rstn_q <= 1'b0;
                            state     <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        det_count <= det_next;
                        pass      <= (det_next == shadow_n) && (err_count == '0) && !timed_out;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prbs_seq_ctrl.sv
// Self-checking bench for prbs_seq_ctrl: directed spec runs plus randomized runs against a run-level model.
module tb_prbs_seq_ctrl;
    import prbs_pkg::*;

    localparam int TO_W  = 16;
    localparam int RES_W = 17;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [31:0]       cfg_pattern = '0;
    logic [7:0]        cfg_n = '0;
    logic [TO_W-1:0]   cfg_timeout = '0;
    logic              busy, done, pass;
    logic [7:0]        det_count, err_count;
    state_t            state_dbg;

    int errors = 0;
    int checks = 0;
    logic [RES_W-1:0] exp_q[$];
    logic [7:0]       stim_byte[$];
    bit               stim_det[$];
    bit               det_chk = 1'b0;

    prbs_seq_ctrl_if dp_if ();

    prbs_seq_ctrl #(.TO_W(TO_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .cfg_pattern (cfg_pattern),
        .cfg_n       (cfg_n),
        .cfg_timeout (cfg_timeout),
        .dp          (dp_if),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .det_count   (det_count),
        .err_count   (err_count),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ref_byte(input logic [31:0] pat, input int i);
        logic [31:0] sh;
        sh = pat >> (8 * (3 - (i % 4)));
        return sh[7:0];
    endfunction

    // det_mode 0: pulse on each group's last byte, 1: random, 2: every cycle
    task automatic fill_stream(input logic [31:0] pat, input int len, input int err_pct, input int det_mode);
        logic [7:0] b;
        stim_byte.delete();
        stim_det.delete();
        for (int i = 0; i < len; i++) begin
            b = ref_byte(pat, i);
            if (int'($urandom_range(99)) < err_pct) b = b ^ 8'($urandom_range(255, 1));
            stim_byte.push_back(b);
            case (det_mode)
                0:       stim_det.push_back((i % 4) == 3);
                1:       stim_det.push_back($urandom_range(3) == 0);
                default: stim_det.push_back(1'b1);
            endcase
        end
    endtask

    task automatic run_one(input string name, input logic [31:0] pat, input logic [7:0] n,
                           input logic [TO_W-1:0] to);
        int r, e, d, i, first_done, done_seen;
        bit timed;
        logic [RES_W-1:0] exp_res, got_res;
        timed = (int'(to) <= 4 * int'(n));
        r = timed ? int'(to) : 4 * int'(n);
        e = 0;
        d = det_chk ? 1 : 0;
        for (int k = 0; k < r; k++) begin
            if (stim_byte[k] != ref_byte(pat, k)) e++;
            if (stim_det[k]) d++;
        end
        if (e > 255) e = 255;
        if (d > 255) d = 255;
        exp_q.push_back({(!timed && e == 0 && d == int'(n)), 8'(d), 8'(e)});

        cfg_pattern = pat; cfg_n = n; cfg_timeout = to; start = 1'b1;
        dp_if.dp_out = '0; dp_if.dp_detected = 1'b0;
        first_done = -1; done_seen = 0; got_res = '0;
        for (int t = 1; t <= r + 6; t++) begin
            tick();
            start = 1'b0;
            if (done) begin
                done_seen++;
                if (first_done < 0) begin
                    first_done = t;
                    got_res = {pass, det_count, err_count};
                end
            end
            if (t == 1) begin
                checks++;
                if ({busy, dp_if.dp_rstn, dp_if.dp_in, dp_if.dp_n} !== {1'b1, 1'b0, pat, n} || state_dbg !== ST_LOAD) begin
                    errors++;
                    $display("FAIL %s_load: busy=%b dp_rstn=%b dp_in=%h dp_n=%0d state=%0d, need busy=1 dp_rstn=0 dp_in=%h dp_n=%0d LOAD",
                             name, busy, dp_if.dp_rstn, dp_if.dp_in, dp_if.dp_n, state_dbg, pat, n);
                end
            end
            if (t == 2) begin
                checks++;
                if ({busy, dp_if.dp_rstn} !== 2'b11 || state_dbg !== ST_RUN) begin
                    errors++;
                    $display("FAIL %s_run_entry: busy=%b dp_rstn=%b state=%0d, need 1 1 RUN",
                             name, busy, dp_if.dp_rstn, state_dbg);
                end
            end
            i = t - 2;
            if (i >= 0 && i < r) begin
                dp_if.dp_out = stim_byte[i]; dp_if.dp_detected = stim_det[i];
            end else if (i == r) begin
                dp_if.dp_out = '0; dp_if.dp_detected = det_chk;
            end else begin
                dp_if.dp_out = '0; dp_if.dp_detected = 1'b0;
            end
        end
        exp_res = exp_q.pop_front();
        checks++;
        if (done_seen != 1 || first_done != r + 3) begin
            errors++;
            $display("FAIL %s_done_timing: pulses=%0d at cycle %0d, need 1 pulse at cycle %0d",
                     name, done_seen, first_done, r + 3);
        end
        checks++;
        if (got_res !== exp_res) begin
            errors++;
            $display("FAIL %s_result: pass=%b det=%0d err=%0d, need pass=%b det=%0d err=%0d",
                     name, got_res[16], got_res[15:8], got_res[7:0], exp_res[16], exp_res[15:8], exp_res[7:0]);
        end
        checks++;
        if ({busy, dp_if.dp_rstn} !== 2'b00 || state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL %s_idle_after: busy=%b dp_rstn=%b state=%0d, need 0 0 IDLE",
                     name, busy, dp_if.dp_rstn, state_dbg);
        end
        det_chk = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({busy, done, pass, det_count, err_count, dp_if.dp_rstn, dp_if.dp_in, dp_if.dp_n} !== '0 || state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_values: busy=%b done=%b pass=%b det=%0d err=%0d dp_rstn=%b dp_in=%h dp_n=%0d, need all 0",
                     busy, done, pass, det_count, err_count, dp_if.dp_rstn, dp_if.dp_in, dp_if.dp_n);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({busy, done, dp_if.dp_rstn} !== 3'b000 || state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_release: busy=%b done=%b dp_rstn=%b state=%0d, need idle", busy, done, dp_if.dp_rstn, state_dbg);
        end
    endtask

    task automatic test_idle_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (done !== 1'b0 || state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL idle_abort: done=%b state=%0d, need done=0 IDLE", done, state_dbg);
        end
    endtask

    task automatic test_clean_run();
        fill_stream(32'hABCD_EFCD, 8, 0, 0);
        run_one("clean_run", 32'hABCD_EFCD, 8'd2, 16'd100);
    endtask

    task automatic test_corrupt_byte();
        fill_stream(32'hABCD_EFCD, 8, 0, 0);
        stim_byte[2] = 8'h00;
        run_one("corrupt_byte", 32'hABCD_EFCD, 8'd2, 16'd100);
    endtask

    task automatic test_check_cycle_detect();
        fill_stream(32'h0102_0304, 4, 0, 0);
        stim_det[3] = 1'b0;
        det_chk = 1'b1;
        run_one("check_cycle_detect", 32'h0102_0304, 8'd1, 16'd50);
    endtask

    task automatic test_timeout();
        fill_stream(32'h5A5A_C3C3, 16, 0, 0);
        run_one("timeout", 32'h5A5A_C3C3, 8'd4, 16'd5);
    endtask

    task automatic test_timeout_tie();
        fill_stream(32'h1357_9BDF, 8, 0, 0);
        run_one("timeout_tie", 32'h1357_9BDF, 8'd2, 16'd8);
    endtask

    task automatic test_saturation();
        fill_stream(32'hF0E1_D2C3, 280, 100, 2);
        run_one("saturation", 32'hF0E1_D2C3, 8'd70, 16'd1000);
    endtask

    task automatic test_random();
        logic [31:0] pat;
        logic [7:0]  n;
        logic [TO_W-1:0] to;
        for (int k = 0; k < 12; k++) begin
            pat = $urandom();
            n = 8'($urandom_range(6, 1));
            if ($urandom_range(3) == 0) to = 16'($urandom_range(4 * int'(n), 1));
            else to = 16'(4 * int'(n) + int'($urandom_range(20, 1)));
            fill_stream(pat, 4 * int'(n), ($urandom_range(1) == 0) ? 0 : 10, int'($urandom_range(1)));
            det_chk = ($urandom_range(7) == 0);
            run_one("random", pat, n, to);
        end
    endtask

    task automatic test_abort();
        logic [31:0] pat;
        pat = 32'h1234_5678;
        fill_stream(pat, 8, 0, 0);
        cfg_pattern = pat; cfg_n = 8'd2; cfg_timeout = 16'd100; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        dp_if.dp_out = stim_byte[0];
        tick();
        dp_if.dp_out = stim_byte[1];
        start = 1'b1; cfg_pattern = 32'hDEAD_BEEF;
        tick();
        start = 1'b0; cfg_pattern = pat;
        checks++;
        if (state_dbg !== ST_RUN || {busy, done, dp_if.dp_rstn} !== 3'b101 || dp_if.dp_in !== pat) begin
            errors++;
            $display("FAIL start_while_busy: state=%0d busy=%b done=%b dp_rstn=%b dp_in=%h, need RUN 1 0 1 %h",
                     state_dbg, busy, done, dp_if.dp_rstn, dp_if.dp_in, pat);
        end
        dp_if.dp_out = stim_byte[2];
        abort = 1'b1;
        tick();
        abort = 1'b0;
        dp_if.dp_out = '0;
        checks++;
        if (state_dbg !== ST_IDLE || {dp_if.dp_rstn, done, pass, busy} !== 4'b0100) begin
            errors++;
            $display("FAIL abort_run: state=%0d dp_rstn=%b done=%b pass=%b busy=%b, need IDLE 0 1 0 0",
                     state_dbg, dp_if.dp_rstn, done, pass, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL abort_done_pulse: done=%b one cycle later, need 0", done);
        end
    endtask

    task automatic test_reset_mid_run();
        bit saw_done;
        fill_stream(32'h8765_4321, 12, 100, 2);
        cfg_pattern = 32'h8765_4321; cfg_n = 8'd3; cfg_timeout = 16'd100; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            dp_if.dp_out = stim_byte[i]; dp_if.dp_detected = stim_det[i];
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, pass, det_count, err_count, dp_if.dp_rstn, dp_if.dp_in, dp_if.dp_n} !== '0 || state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_mid_run: busy=%b done=%b pass=%b det=%0d err=%0d dp_rstn=%b dp_in=%h dp_n=%0d, need all 0",
                     busy, done, pass, det_count, err_count, dp_if.dp_rstn, dp_if.dp_in, dp_if.dp_n);
        end
        dp_if.dp_out = '0; dp_if.dp_detected = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        tick();
        if (done) saw_done = 1'b1;
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL reset_no_done: done=1 seen after reset, need 0");
        end
        cfg_n = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({done, pass, busy} !== 3'b100 || state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL reject_n0: done=%b pass=%b busy=%b state=%0d, need 1 0 0 IDLE", done, pass, busy, state_dbg);
        end
        tick();
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL reject_n0_after: done=%b busy=%b, need 0 0", done, busy);
        end
    endtask

    initial begin
        dp_if.dp_out = '0;
        dp_if.dp_detected = 1'b0;
        test_reset();
        test_idle_abort();
        test_clean_run();
        test_corrupt_byte();
        test_check_cycle_detect();
        test_timeout();
        test_timeout_tie();
        test_saturation();
        test_abort();
        test_random();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
